task_3_ctrl: RTL and testbench
==============================

// Module: task_3_ctrl
// PURPOSE
//   Packet-level sequencer for the task 3 echo datapath (input byte packer -> delay_echo -> output packer).
//   Admits one input packet at a time, then issues exactly one datapath enable per 32-bit word.
//   Waits for every processed word to return, requests the latency word, and holds the answer phase until the packet is delivered.
//   Sits between the task manager handshake and the task_3_in / task_3_out / latency-measure enables.
// PARAMETERS
//   MAX_BYTES      512   max input bytes counted per packet; excess bytes are ignored
//   WORD_BYTES     4     bytes per datapath word (DATA_WIDTH_IN/8)
//   TIMEOUT_CYCLES 1024  max DRAIN cycles before forced completion
//   CNT_W          12    width of byte/word/latency counters (>= clog2(MAX_BYTES)+1)
// PORTS
//   i_clk           in   1      clock
//   i_rst           in   1      synchronous reset, active high
//   i_tdata_valid   in   1      input byte strobe from task manager
//   i_tdata_last    in   1      last byte of input packet (qualified by i_tdata_valid)
//   o_tready        out  1      data request to task manager; high only in LOAD
//   o_proc_en       out  1      one-cycle-per-word enable to datapath read side
//   i_out_valid     in   1      datapath output word valid (delay_echo o_valid)
//   o_lat_req       out  1      one-cycle pulse: push latency word into output packer
//   o_latency       out  CNT_W  cycles from first o_proc_en to last counted i_out_valid
//   i_tmanager_ready in  1      task manager ready for answer
//   i_answer_last   in   1      output packer last word
//   o_answer_ready  out  1      answer phase active; high only in SEND
//   o_pkt_bytes     out  CNT_W  bytes accepted in current packet (saturates at MAX_BYTES)
//   o_busy          out  1      state != IDLE
//   o_overflow      out  1      sticky until next LOAD entry: packet exceeded MAX_BYTES
//   o_timeout       out  1      one-cycle pulse on DRAIN timeout
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; all counters 0. Reset mid-packet aborts immediately; no lat_req is issued.
//   FSM: IDLE -> LOAD -> PROC -> DRAIN -> LAT -> SEND -> IDLE.
//   IDLE: single cycle, then LOAD. Clears byte, word and out counters and o_latency.
//     o_overflow is NOT cleared in IDLE; it is cleared on LOAD entry.
//   LOAD: o_tready=1.
//     On each i_tdata_valid: byte_cnt++ while byte_cnt<MAX_BYTES. If byte_cnt==MAX_BYTES, the byte is dropped and o_overflow is set.
//     On i_tdata_valid & i_tdata_last: n_words = ceil(byte_cnt_final/WORD_BYTES), where byte_cnt_final includes the last byte. Next state PROC.
//     i_tdata_last without i_tdata_valid is ignored.
//   PROC: o_proc_en=1 for exactly n_words consecutive cycles; the first is the cycle after LOAD exits. Then DRAIN.
//     Latency counter starts at the first o_proc_en cycle.
//   out_cnt: increments on i_out_valid in PROC and DRAIN only. i_out_valid in any other state is ignored.
//     Saturates at n_words; extra valids do not count.
//   o_latency: cycles elapsed since first o_proc_en, latched at the cycle out_cnt reaches n_words.
//     Held until the next IDLE.
//   DRAIN: exit to LAT in the cycle after out_cnt==n_words.
//     If TIMEOUT_CYCLES elapse in DRAIN first: pulse o_timeout, o_latency={CNT_W{1}}, go to LAT.
//   LAT: o_lat_req=1 for exactly one cycle; next SEND.
//   SEND: o_answer_ready=1. Exit to IDLE when i_answer_last & i_tmanager_ready in the same cycle.
//     i_answer_last without i_tmanager_ready does not exit.
//   Input handshake: o_tready=0 outside LOAD. Bytes arriving outside LOAD are ignored.
//   Simultaneous out_cnt completion and timeout in the same cycle: completion wins; no o_timeout.
//   All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//   Packet of 8 bytes, datapath returns 2 valids 3 cycles after each enable:
//     -> o_proc_en high exactly 2 cycles, o_latency=4, one o_lat_req, o_pkt_bytes=8.
//   Packet of 5 bytes -> n_words=2, two o_proc_en cycles. Packet of 1 byte -> one o_proc_en cycle.
//   MAX_BYTES=16, send 20 bytes then last:
//     -> o_pkt_bytes=16, o_overflow=1 through SEND, cleared on next LOAD entry.
//   No i_out_valid returned -> o_timeout pulse after 1024 DRAIN cycles, o_latency=12'hFFF, o_lat_req pulse, SEND entered.
//   In SEND, i_answer_last with i_tmanager_ready=0 for 5 cycles, then both high -> remains SEND, then IDLE next cycle.
//   Assert i_rst during PROC -> next cycle IDLE, all outputs 0, no o_lat_req; next packet processes normally.

Source files
------------

// File: rtl/task_3_ctrl.sv
// Packet sequencer for the task 3 echo datapath: loads one packet, issues one enable per word,
// waits for the words to return (or times out), requests the latency word, then holds the answer phase.
module task_3_ctrl #(
   parameter int MAX_BYTES      = 512,
   parameter int WORD_BYTES     = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 12
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_tdata_valid,
   input  logic             i_tdata_last,
   output logic             o_tready,
   output logic             o_proc_en,
   input  logic             i_out_valid,
   output logic             o_lat_req,
   output logic [CNT_W-1:0] o_latency,
   input  logic             i_tmanager_ready,
   input  logic             i_answer_last,
   output logic             o_answer_ready,
   output logic [CNT_W-1:0] o_pkt_bytes,
   output logic             o_busy,
   output logic             o_overflow,
   output logic             o_timeout
);

   localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0] WB_C    = CNT_W'(WORD_BYTES);
   localparam logic [CNT_W-1:0] WB_M1   = CNT_W'(WORD_BYTES - 1);
   localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PROC, S_DRAIN, S_LAT, S_SEND
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [CNT_W-1:0] nwords_q, nwords_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic [CNT_W-1:0] latency_q, latency_d;
   logic [TO_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic             ovf_q, ovf_d;
   logic             timeout_q, timeout_d;
   logic             tready_q, tready_d;
   logic             proc_en_q, proc_en_d;
   logic             lat_req_q, lat_req_d;
   logic             ans_rdy_q, ans_rdy_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] byte_fin;
   logic             out_fin;

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      nwords_d    = nwords_q;
      word_cnt_d  = word_cnt_q;
      out_cnt_d   = out_cnt_q;
      lat_cnt_d   = lat_cnt_q;
      latency_d   = latency_q;
      drain_cnt_d = drain_cnt_q;
      ovf_d       = ovf_q;
      timeout_d   = 1'b0;
      out_fin     = 1'b0;
      // byte count including the current byte, as used for the word count on the last byte
      byte_fin    = byte_cnt_q + ((byte_cnt_q < MAX_C) ? ONE : '0);

      if (state_q == S_PROC || state_q == S_DRAIN) begin
         lat_cnt_d = lat_cnt_q + ONE;
         if (i_out_valid && out_cnt_q < nwords_q) begin
            out_cnt_d = out_cnt_q + ONE;
            if (out_cnt_q == nwords_q - ONE) begin
               out_fin   = 1'b1;
               latency_d = lat_cnt_q;
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            byte_cnt_d  = '0;
            nwords_d    = '0;
            word_cnt_d  = '0;
            out_cnt_d   = '0;
            lat_cnt_d   = '0;
            latency_d   = '0;
            drain_cnt_d = '0;
            ovf_d       = 1'b0;   // lands on LOAD entry; IDLE itself still shows the old flag
            state_d     = S_LOAD;
         end
         S_LOAD: begin
            if (i_tdata_valid) begin
               if (byte_cnt_q < MAX_C) byte_cnt_d = byte_cnt_q + ONE;
               else                    ovf_d      = 1'b1;
               if (i_tdata_last) begin
                  nwords_d = (byte_fin + WB_M1) / WB_C;
                  state_d  = S_PROC;
               end
            end
         end
         S_PROC: begin
            word_cnt_d = word_cnt_q + ONE;
            if (word_cnt_q == nwords_q - ONE) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            drain_cnt_d = drain_cnt_q + TO_ONE;
            if (out_cnt_q == nwords_q) begin
               state_d = S_LAT;
            end else if (drain_cnt_q == TO_LAST && !out_fin) begin
               // a word completing on the last allowed cycle beats the timeout
               timeout_d = 1'b1;
               latency_d = '1;
               state_d   = S_LAT;
            end
         end
         S_LAT:  state_d = S_SEND;
         S_SEND: if (i_answer_last && i_tmanager_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      tready_d  = (state_d == S_LOAD);
      proc_en_d = (state_d == S_PROC);
      lat_req_d = (state_d == S_LAT);
      ans_rdy_d = (state_d == S_SEND);
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         byte_cnt_q  <= '0;
         nwords_q    <= '0;
         word_cnt_q  <= '0;
         out_cnt_q   <= '0;
         lat_cnt_q   <= '0;
         latency_q   <= '0;
         drain_cnt_q <= '0;
         ovf_q       <= 1'b0;
         timeout_q   <= 1'b0;
         tready_q    <= 1'b0;
         proc_en_q   <= 1'b0;
         lat_req_q   <= 1'b0;
         ans_rdy_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         nwords_q    <= nwords_d;
         word_cnt_q  <= word_cnt_d;
         out_cnt_q   <= out_cnt_d;
         lat_cnt_q   <= lat_cnt_d;
         latency_q   <= latency_d;
         drain_cnt_q <= drain_cnt_d;
         ovf_q       <= ovf_d;
         timeout_q   <= timeout_d;
         tready_q    <= tready_d;
         proc_en_q   <= proc_en_d;
         lat_req_q   <= lat_req_d;
         ans_rdy_q   <= ans_rdy_d;
         busy_q      <= busy_d;
      end
   end

   assign o_tready       = tready_q;
   assign o_proc_en      = proc_en_q;
   assign o_lat_req      = lat_req_q;
   assign o_latency      = latency_q;
   assign o_answer_ready = ans_rdy_q;
   assign o_pkt_bytes    = byte_cnt_q;
   assign o_busy         = busy_q;
   assign o_overflow     = ovf_q;
   assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_task_3_ctrl.sv
// Bench for task_3_ctrl: directed packet table, randomized packets against a packet-level model,
// and a mid-packet reset sequence. A behavioural echo datapath returns each enable after a set delay.
module tb_task_3_ctrl;

   localparam int MAXB = 16;
   localparam int TO   = 1024;
   localparam int CW   = 12;

   typedef struct {
      int len; int d; bit echo; int stall;
      int words; int lat; int bytes; bit ovf; bit to;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tvalid = 1'b0, tlast = 1'b0, out_valid = 1'b0, tmgr_rdy = 1'b0, ans_last = 1'b0;
   logic tready, proc_en, lat_req, ans_rdy, busy, ovf, tmo;
   logic [CW-1:0] latency, pkt_bytes;
   logic [30:0]   all_outs;

   int n_cmp = 0, n_err = 0;
   int cyc = 0, echo_d = 3;
   bit echo_on = 1'b0, noise_on = 1'b0;
   int rq[$];
   int pe_cnt = 0, pe_rise = 0, lr_cnt = 0, to_cnt = 0, drain_cyc = 0, excl_err = 0;
   logic prev_pe = 1'b0;

   always #5 clk = ~clk;

   task_3_ctrl #(.MAX_BYTES(MAXB), .WORD_BYTES(4), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_tdata_valid(tvalid), .i_tdata_last(tlast),
      .o_tready(tready), .o_proc_en(proc_en), .i_out_valid(out_valid),
      .o_lat_req(lat_req), .o_latency(latency), .i_tmanager_ready(tmgr_rdy),
      .i_answer_last(ans_last), .o_answer_ready(ans_rdy), .o_pkt_bytes(pkt_bytes),
      .o_busy(busy), .o_overflow(ovf), .o_timeout(tmo)
   );

   assign all_outs = {tready, proc_en, lat_req, ans_rdy, busy, ovf, tmo, latency, pkt_bytes};

   // echo datapath: each enable comes back echo_d cycles later; noise valids where they must be ignored
   always @(negedge clk) begin : datapath
      logic v;
      cyc++;
      if (proc_en && echo_on) rq.push_back(cyc + echo_d);
      while (rq.size() > 0 && rq[0] < cyc) void'(rq.pop_front());
      v = 1'b0;
      if (rq.size() > 0 && rq[0] == cyc) begin
         v = 1'b1;
         void'(rq.pop_front());
      end
      if (noise_on && (tready || ans_rdy || !busy) && $urandom_range(0, 1) == 1) v = 1'b1;
      out_valid = v;
   end

   always @(negedge clk) begin : monitor
      if (proc_en) pe_cnt++;
      if (proc_en && !prev_pe) pe_rise++;
      prev_pe = proc_en;
      if (lat_req) lr_cnt++;
      if (tmo) to_cnt++;
      if (busy && !tready && !proc_en && !lat_req && !ans_rdy) drain_cyc++;
      if (int'(tready) + int'(proc_en) + int'(lat_req) + int'(ans_rdy) > 1) excl_err++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0d required %0d", nm, act, exp);
      end
   endtask

   // packet-level expectations from the byte count and echo delay
   function automatic vec_t model(input int len, input int d, input bit echo, input int stall);
      vec_t v;
      v.len   = len; v.d = d; v.echo = echo; v.stall = stall;
      v.bytes = (len > MAXB) ? MAXB : len;
      v.words = (v.bytes + 3) / 4;
      v.ovf   = (len > MAXB);
      v.to    = !echo || (d > TO);
      v.lat   = v.to ? (1 << CW) - 1 : v.words - 1 + d;
      return v;
   endfunction

   task automatic send_bytes(input int len);
      for (int i = 0; i < len; i++) begin
         repeat ($urandom_range(0, 2)) begin
            tvalid = 1'b0;
            tlast  = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         tvalid = 1'b1;
         tlast  = (i == len - 1);
         @(negedge clk);
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   task automatic run_pkt(input vec_t v, input string tag);
      int k, b_pe, b_rise, b_lr, b_to, b_dr;
      echo_d  = v.d;
      echo_on = v.echo;
      k = 0;
      while (!tready && k < 200) begin @(negedge clk); k++; end
      chk({tag, "_tready"}, 32'(tready), 1);
      if (!tready) return;
      chk({tag, "_ovf_clr"}, 32'(ovf), 0);
      b_pe = pe_cnt; b_rise = pe_rise; b_lr = lr_cnt; b_to = to_cnt; b_dr = drain_cyc;
      send_bytes(v.len);
      k = 0;
      while (!ans_rdy && k < TO + 300) begin @(negedge clk); k++; end
      chk({tag, "_send"}, 32'(ans_rdy), 1);
      if (!ans_rdy) return;
      chk({tag, "_latency"}, 32'(latency), v.lat);
      chk({tag, "_bytes"}, 32'(pkt_bytes), v.bytes);
      chk({tag, "_ovf"}, 32'(ovf), 32'(v.ovf));
      chk({tag, "_proc_cycles"}, pe_cnt - b_pe, v.words);
      chk({tag, "_proc_bursts"}, pe_rise - b_rise, 1);
      chk({tag, "_lat_req"}, lr_cnt - b_lr, 1);
      chk({tag, "_timeout"}, to_cnt - b_to, 32'(v.to));
      if (v.to) chk({tag, "_drain_len"}, drain_cyc - b_dr, TO);
      for (int s = 0; s < v.stall; s++) begin
         ans_last = (s % 2 == 0);
         tmgr_rdy = (s % 2 == 1);
         @(negedge clk);
         chk({tag, "_hold_send"}, 32'(ans_rdy), 1);
      end
      ans_last = 1'b1;
      tmgr_rdy = 1'b1;
      @(negedge clk);
      ans_last = 1'b0;
      tmgr_rdy = 1'b0;
      chk({tag, "_idle"}, 32'({ans_rdy, busy}), 0);
      chk({tag, "_ovf_in_idle"}, 32'(ovf), 32'(v.ovf));
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t tbl[10];
      int k, b;
      tbl[0] = '{8,    3, 1'b1, 0, 2, 4,     8,  1'b0, 1'b0};
      tbl[1] = '{5,    3, 1'b1, 1, 2, 4,     5,  1'b0, 1'b0};
      tbl[2] = '{1,    3, 1'b1, 0, 1, 3,     1,  1'b0, 1'b0};
      tbl[3] = '{20,   3, 1'b1, 2, 4, 6,     16, 1'b1, 1'b0};
      tbl[4] = '{3,    2, 1'b1, 0, 1, 2,     3,  1'b0, 1'b0};
      tbl[5] = '{4,    0, 1'b0, 5, 1, 'hFFF, 4,  1'b0, 1'b1};
      tbl[6] = '{16,   0, 1'b1, 0, 4, 3,     16, 1'b0, 1'b0};
      tbl[7] = '{17,   5, 1'b1, 1, 4, 8,     16, 1'b1, 1'b0};
      tbl[8] = '{4, 1024, 1'b1, 0, 1, 1024,  4,  1'b0, 1'b0};
      tbl[9] = '{4, 1025, 1'b1, 0, 1, 'hFFF, 4,  1'b0, 1'b1};

      repeat (3) @(negedge clk);
      chk("reset_outs", 32'(all_outs), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("load_after_reset", 32'({busy, tready}), 3);
      noise_on = 1'b1;

      for (int i = 0; i < 10; i++) run_pkt(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 30; i++)
         run_pkt(model($urandom_range(1, 24), $urandom_range(0, 6), 1'b1, $urandom_range(0, 3)),
                 $sformatf("rnd%0d", i));

      // reset while enables are being issued
      echo_on = 1'b1;
      echo_d  = 3;
      k = 0;
      while (!tready && k < 200) begin @(negedge clk); k++; end
      send_bytes(8);
      k = 0;
      while (!proc_en && k < 20) begin @(negedge clk); k++; end
      chk("rst_reach_proc", 32'(proc_en), 1);
      b   = lr_cnt;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_outs", 32'(all_outs), 0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("rst_no_lat_req", lr_cnt - b, 0);
      run_pkt(model(8, 3, 1'b1, 1), "post_rst");

      chk("phase_exclusive", excl_err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
